keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 190 +++++++++++++++++++
 tb/tb_keypad_entry.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced one-hot keypad reader with BCD digit buffer
module keypad_entry #(
  parameter int N_KEYS          = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     keypad,
  input  logic                  hold,
  input  logic                  clear,
  output logic [3:0]            BCD,
  output logic                  key_valid,
  output logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            count,
  output logic                  full,
  output logic                  error,
  output logic                  overflow
);

  // Counter holds 0..DEBOUNCE_CYCLES inclusive, so it can never wrap.
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   DC_L     = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0]      DIGITS_L = 4'(DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [CW-1:0]          cnt_inc;
  logic                   cnt_done;
  logic [N_KEYS-1:0]      cap, cap_n;
  logic                   key_zero;
  logic                   key_onehot;
  logic [3:0]             key_code;
  logic                   accept;
  logic                   err_n;
  logic                   kv_n;
  logic                   ovf_n;
  logic [3:0]             bcd_n;
  logic [4*DIGITS-1:0]    digits_n;
  logic [3:0]             count_n;
  logic                   full_n;

  // Index of the highest set line; for a one-hot value this is the key number.
  function automatic logic [3:0] key_index(input logic [N_KEYS-1:0] k);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Classify the raw sample and precompute the counter step.
  always_comb begin
    key_zero   = (keypad == '0);
    key_onehot = !key_zero && ((keypad & (keypad - N_KEYS'(1))) == '0);
    key_code   = key_index(keypad);
    cnt_inc    = cnt + CW'(1);
    cnt_done   = (cnt_inc == DC_L);
  end

  // Debounce FSM next-state: press qualification, held wait, release qualification.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    accept  = 1'b0;
    err_n   = 1'b0;
    if (hold) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_onehot) begin
            cap_n = keypad;
            cnt_n = CW'(1);
            if (DEBOUNCE_CYCLES == 1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end else if (!key_zero) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = RELEASE;
          end
        end
        DEBOUNCE: begin
          if (keypad == cap) begin
            cnt_n = cnt_inc;
            if (cnt_done) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          // Only a full release matters here; wiggles while held are ignored.
          if (key_zero) begin
            if (DEBOUNCE_CYCLES == 1) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n   = CW'(1);
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (key_zero) begin
            if (cnt_done) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output and digit-buffer next values; clear beats a simultaneous accept.
  always_comb begin
    bcd_n    = BCD;
    kv_n     = accept;
    ovf_n    = 1'b0;
    digits_n = digits;
    count_n  = count;
    if (accept) begin
      bcd_n = key_code;
      if (count == DIGITS_L) ovf_n = 1'b1;
    end
    if (clear) begin
      digits_n = '0;
      count_n  = '0;
    end else if (accept && (count != DIGITS_L)) begin
      digits_n      = digits << 4;
      digits_n[3:0] = key_code;
      count_n       = count + 4'd1;
    end
    full_n = (count_n == DIGITS_L);
  end

  // State and registered outputs; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      BCD       <= '0;
      key_valid <= 1'b0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      digits    <= '0;
      count     <= '0;
      full      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cap       <= cap_n;
      BCD       <= bcd_n;
      key_valid <= kv_n;
      error     <= err_n;
      overflow  <= ovf_n;
      digits    <= digits_n;
      count     <= count_n;
      full      <= full_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keypad;
  logic        hold;
  logic        clear;
  logic [3:0]  BCD;
  logic        key_valid;
  logic [15:0] digits;
  logic [3:0]  count;
  logic        full;
  logic        error;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;

  keypad_entry #(
    .N_KEYS(10),
    .DEBOUNCE_CYCLES(4),
    .DIGITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keypad(keypad),
    .hold(hold),
    .clear(clear),
    .BCD(BCD),
    .key_valid(key_valid),
    .digits(digits),
    .count(count),
    .full(full),
    .error(error),
    .overflow(overflow)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] key(input int i);
    logic [9:0] one;
    one = 10'd1;
    return one << i;
  endfunction

  // One clock: sample 1 ns after the rising edge and tally pulses.
  task automatic step();
    @(posedge clk);
    #1;
    kv_cnt  += int'(key_valid);
    err_cnt += int'(error);
    ovf_cnt += int'(overflow);
  endtask

  task automatic run(input int n, input logic [9:0] kp);
    keypad = kp;
    repeat (n) step();
  endtask

  task automatic press(input int k);
    run(5, key(k));
    run(6, 10'd0);
  endtask

  initial begin
    rst    = 1'b1;
    keypad = '0;
    hold   = 1'b0;
    clear  = 1'b0;
    step();
    step();
    check("rst_bcd",   32'(BCD), 0);
    check("rst_kv",    32'(key_valid), 0);
    check("rst_dig",   32'(digits), 0);
    check("rst_cnt",   32'(count), 0);
    check("rst_full",  32'(full), 0);
    check("rst_err",   32'(error), 0);
    check("rst_ovf",   32'(overflow), 0);
    rst = 1'b0;

    // Single key held 10 cycles: accepted on the 4th sample edge only.
    kv_cnt = 0;
    keypad = key(3);
    step(); step(); step();
    check("t1_early_kv", 32'(kv_cnt), 0);
    step();
    check("t1_kv",   32'(key_valid), 1);
    check("t1_bcd",  32'(BCD), 3);
    check("t1_dig",  32'(digits), 32'h0003);
    check("t1_cnt",  32'(count), 1);
    run(6, key(3));
    check("t1_once", 32'(kv_cnt), 1);
    run(6, 10'd0);

    // Bounce: first contact discarded, stable run accepted.
    kv_cnt = 0;
    run(1, key(5));
    run(1, 10'd0);
    check("t2_bounce_kv", 32'(kv_cnt), 0);
    run(4, key(5));
    check("t2_kv",  32'(kv_cnt), 1);
    check("t2_bcd", 32'(BCD), 5);
    check("t2_dig", 32'(digits), 32'h0035);
    check("t2_cnt", 32'(count), 2);
    run(6, 10'd0);

    // Fill the buffer, then overflow on the fifth key.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3_clr_cnt", 32'(count), 0);
    check("t3_clr_dig", 32'(digits), 0);
    press(1);
    press(2);
    press(3);
    check("t3_notfull", 32'(full), 0);
    press(4);
    check("t3_dig",  32'(digits), 32'h1234);
    check("t3_full", 32'(full), 1);
    check("t3_cnt",  32'(count), 4);
    kv_cnt = 0;
    ovf_cnt = 0;
    press(7);
    check("t3_ovf_kv",  32'(kv_cnt), 1);
    check("t3_ovf",     32'(ovf_cnt), 1);
    check("t3_ovf_bcd", 32'(BCD), 7);
    check("t3_ovf_dig", 32'(digits), 32'h1234);
    check("t3_ovf_cnt", 32'(count), 4);

    // Multi-key press: one error pulse, then a full release is required.
    kv_cnt = 0;
    err_cnt = 0;
    run(3, 10'b0000000011);
    check("t4_err", 32'(err_cnt), 1);
    check("t4_kv",  32'(kv_cnt), 0);
    run(3, 10'd0);
    run(5, key(1));
    run(3, 10'd0);
    check("t4_locked_kv", 32'(kv_cnt), 0);
    run(1, 10'd0);
    press(1);
    check("t4_after_kv",  32'(kv_cnt), 1);
    check("t4_after_err", 32'(err_cnt), 1);

    // Clear coinciding with the accept of key 9.
    keypad = key(9);
    step(); step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_kv",   32'(key_valid), 1);
    check("t5_bcd",  32'(BCD), 9);
    check("t5_cnt",  32'(count), 0);
    check("t5_dig",  32'(digits), 0);
    check("t5_full", 32'(full), 0);
    run(2, key(9));
    run(6, 10'd0);

    // Hold suppresses a pressed key; after hold drops it is accepted once.
    hold = 1'b1;
    kv_cnt = 0;
    err_cnt = 0;
    run(6, key(2));
    check("t6_hold_kv",  32'(kv_cnt), 0);
    check("t6_hold_bcd", 32'(BCD), 9);
    hold = 1'b0;
    run(3, key(2));
    check("t6_early_kv", 32'(kv_cnt), 0);
    step();
    check("t6_kv",  32'(key_valid), 1);
    check("t6_bcd", 32'(BCD), 2);
    check("t6_dig", 32'(digits), 32'h0002);
    check("t6_cnt", 32'(count), 1);
    run(5, key(2));
    check("t6_once", 32'(kv_cnt), 1);
    run(6, 10'd0);

    // Reset mid-debounce discards the pending key.
    keypad = key(6);
    step(); step();
    rst = 1'b1;
    hold = 1'b1;
    clear = 1'b1;
    step();
    rst = 1'b0;
    hold = 1'b0;
    clear = 1'b0;
    check("t7_rst_bcd", 32'(BCD), 0);
    check("t7_rst_cnt", 32'(count), 0);
    check("t7_rst_dig", 32'(digits), 0);
    kv_cnt = 0;
    run(3, key(6));
    check("t7_early_kv", 32'(kv_cnt), 0);
    step();
    check("t7_kv",  32'(key_valid), 1);
    check("t7_bcd", 32'(BCD), 6);
    run(6, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
